multi_channel_sample_bridge: RTL and testbench

Parametrised bridge between N sample producers (music_player voices) and the adau1761_codec headphone inputs. Buffers each channel in a small FIFO, drains one sample per channel on each codec new_frame pulse, mixes to left/right with saturation, and drives left-justified 24-bit headphone words. It also produces a registered display tap (sample plus strobe) for wave_display_top, replacing the ad-hoc sample flop and the LED tap at the top level.

---
 rtl/multi_channel_sample_bridge_pkg.sv | 39 +++
 rtl/multi_channel_sample_bridge_if.sv | 14 +
 rtl/multi_channel_sample_bridge_fifo.sv | 66 ++++++
 rtl/multi_channel_sample_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_multi_channel_sample_bridge.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_channel_sample_bridge_pkg.sv
// sample_bridge_pkg: shared definitions for multi_channel_sample_bridge.
//   - mode encodings for stereo_mode
//   - bridge FSM state type
//   - sat_to_sample: clamps a wide signed sum into a signed sample range
package sample_bridge_pkg;

  localparam logic MODE_MONO   = 1'b0;
  localparam logic MODE_STEREO = 1'b1;

  // Working width for saturation; wide enough for any legal mix sum.
  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    MIX  = 2'd2
  } bridge_state_e;

  // Clamp sum to [-2^(sample_w-1), 2^(sample_w-1)-1]; caller keeps the low sample_w bits.
  function automatic logic signed [SAT_W-1:0] sat_to_sample(
    input logic signed [SAT_W-1:0] sum,
    input int                      sample_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    hi = (32'sd1 <<< (sample_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (sum > hi) begin
      res = hi;
    end else if (sum < lo) begin
      res = lo;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/multi_channel_sample_bridge_if.sv
// multi_channel_sample_bridge_if: producer-side sample bus.
//   sample_in    : NUM_CH packed signed samples, ch0 in LSBs
//   sample_valid : per-channel push strobe
// master = producers (voices), slave = bridge.
interface multi_channel_sample_bridge_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16
);
  logic [NUM_CH*SAMPLE_W-1:0] sample_in;
  logic [NUM_CH-1:0]          sample_valid;

  modport master (output sample_in, output sample_valid);
  modport slave  (input  sample_in, input  sample_valid);
endinterface

// File: rtl/multi_channel_sample_bridge_fifo.sv
// sample_fifo: W x DEPTH synchronous FIFO with occupancy count.
//   push/din      : write request; dropped (overflow pulse) when full and not popping
//   pop/dout      : read request; dout shows the head entry (valid when !empty)
//   count, empty  : occupancy
//   overflow      : one-cycle pulse when a push is dropped
// A pop on an empty FIFO does nothing, even with a same-cycle push.
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          do_pop_s;
  logic          do_push_s;

  // Qualify requests: pop needs data; a full FIFO still accepts a push when it pops.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop & (count_r != {CW{1'b0}});
    do_push_s = push & (~full_s | do_pop_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = (count_r == {CW{1'b0}});
  assign overflow = push & ~do_push_s;

endmodule

// File: rtl/multi_channel_sample_bridge.sv
// multi_channel_sample_bridge: buffers NUM_CH producer channels, drains one
// sample per channel on each codec new_frame, mixes to left/right with
// saturation and drives left-justified OUT_W-bit headphone words.
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   prod (slave modport)   : sample_in / sample_valid from the voices
//   stereo_mode            : 0 mono mix, 1 even->left / odd->right
//   new_frame              : codec frame request pulse
//   clear_status           : clears sticky flags (a same-cycle set wins)
//   hphone_l, hphone_r     : codec words {sat, zeros}
//   tap_sample, tap_valid  : saturated left mix + one-cycle strobe for display
//   fill_level             : per-channel FIFO occupancy
//   overflow, underrun     : per-channel sticky flags
//   frame_miss             : sticky, new_frame arrived while busy
//   peak_l, peak_r         : 4-bit level meters, only with SAMPLE_BRIDGE_PEAK_METER_EN
module multi_channel_sample_bridge
  import sample_bridge_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int SAMPLE_W         = 16,
  parameter int OUT_W            = 24,
  parameter int DEPTH            = 4,
  parameter bit HOLD_ON_UNDERRUN = 1'b1,
  parameter int METER_DECAY      = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  multi_channel_sample_bridge_if.slave         prod,
  input  logic                                 stereo_mode,
  input  logic                                 new_frame,
  input  logic                                 clear_status,
  output logic [OUT_W-1:0]                     hphone_l,
  output logic [OUT_W-1:0]                     hphone_r,
  output logic [SAMPLE_W-1:0]                  tap_sample,
  output logic                                 tap_valid,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  fill_level,
  output logic [NUM_CH-1:0]                    overflow,
  output logic [NUM_CH-1:0]                    underrun,
  output logic                                 frame_miss
`ifdef SAMPLE_BRIDGE_PEAK_METER_EN
  ,
  output logic [3:0]                           peak_l,
  output logic [3:0]                           peak_r
`endif
);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int SUM_W    = SAMPLE_W + $clog2(NUM_CH) + 1;
  localparam bit MIRROR_R = (NUM_CH == 1);

  bridge_state_e        state_r;
  logic                 mode_r;
  logic [SAMPLE_W-1:0]  pop_val_r   [NUM_CH];
  logic [SAMPLE_W-1:0]  held_r      [NUM_CH];
  logic [SAMPLE_W-1:0]  fifo_dout_s [NUM_CH];
  logic [CW-1:0]        fifo_count_s[NUM_CH];
  logic [NUM_CH-1:0]    fifo_empty_s;
  logic [NUM_CH-1:0]    fifo_ovf_s;
  logic                 pop_s;
  logic signed [SUM_W-1:0] ext_s;
  logic signed [SUM_W-1:0] sum_l_s;
  logic signed [SUM_W-1:0] sum_r_s;
  logic signed [SAT_W-1:0] sat_full_l_s;
  logic signed [SAT_W-1:0] sat_full_r_s;
  logic [SAMPLE_W-1:0]  sat_l_s;
  logic [SAMPLE_W-1:0]  sat_r_s;

  assign pop_s = (state_r == POP);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sample_fifo #(.W(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (reset_n),
      .push     (prod.sample_valid[g]),
      .pop      (pop_s),
      .din      (prod.sample_in[g*SAMPLE_W +: SAMPLE_W]),
      .dout     (fifo_dout_s[g]),
      .count    (fifo_count_s[g]),
      .empty    (fifo_empty_s[g]),
      .overflow (fifo_ovf_s[g])
    );
    assign fill_level[g*CW +: CW] = fifo_count_s[g];
  end

  // Mix the popped samples into left/right sums and saturate them.
  always_comb begin
    sum_l_s = {SUM_W{1'b0}};
    sum_r_s = {SUM_W{1'b0}};
    ext_s   = {SUM_W{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ext_s   = SUM_W'($signed(pop_val_r[ch]));
      sum_l_s = sum_l_s + (((mode_r != MODE_STEREO) || ((ch % 2) == 0)) ? ext_s : {SUM_W{1'b0}});
      sum_r_s = sum_r_s + (((mode_r != MODE_STEREO) || ((ch % 2) == 1) || MIRROR_R) ? ext_s : {SUM_W{1'b0}});
    end
    sat_full_l_s = sat_to_sample(SAT_W'(sum_l_s), SAMPLE_W);
    sat_full_r_s = sat_to_sample(SAT_W'(sum_r_s), SAMPLE_W);
    sat_l_s      = sat_full_l_s[SAMPLE_W-1:0];
    sat_r_s      = sat_full_r_s[SAMPLE_W-1:0];
  end

  // Frame FSM: IDLE waits for new_frame, POP latches one sample per channel, MIX drives outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      mode_r     <= MODE_MONO;
      hphone_l   <= {OUT_W{1'b0}};
      hphone_r   <= {OUT_W{1'b0}};
      tap_sample <= {SAMPLE_W{1'b0}};
      tap_valid  <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pop_val_r[ch] <= {SAMPLE_W{1'b0}};
        held_r[ch]    <= {SAMPLE_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          tap_valid <= 1'b0;
          if (new_frame) state_r <= POP;
          else           state_r <= IDLE;
        end
        POP: begin
          tap_valid <= 1'b0;
          mode_r    <= stereo_mode;
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if (fifo_empty_s[ch]) begin
              pop_val_r[ch] <= HOLD_ON_UNDERRUN ? held_r[ch] : {SAMPLE_W{1'b0}};
            end else begin
              pop_val_r[ch] <= fifo_dout_s[ch];
              held_r[ch]    <= fifo_dout_s[ch];
            end
          end
          state_r <= MIX;
        end
        MIX: begin
          hphone_l   <= OUT_W'(sat_l_s) << (OUT_W - SAMPLE_W);
          hphone_r   <= OUT_W'(sat_r_s) << (OUT_W - SAMPLE_W);
          tap_sample <= sat_l_s;
          tap_valid  <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          tap_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as clear_status wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= {NUM_CH{1'b0}};
      underrun   <= {NUM_CH{1'b0}};
      frame_miss <= 1'b0;
    end else begin
      overflow   <= fifo_ovf_s | (overflow & ~{NUM_CH{clear_status}});
      underrun   <= (pop_s ? fifo_empty_s : {NUM_CH{1'b0}}) | (underrun & ~{NUM_CH{clear_status}});
      frame_miss <= (new_frame & (state_r != IDLE)) | (frame_miss & ~clear_status);
    end
  end

`ifdef SAMPLE_BRIDGE_PEAK_METER_EN
  localparam int DEC_W = $clog2(METER_DECAY) + 1;

  logic [DEC_W-1:0] decay_cnt_r;
  logic             decay_s;
  logic [3:0]       nib_l_s;
  logic [3:0]       nib_r_s;
  logic [3:0]       base_l_s;
  logic [3:0]       base_r_s;

  // Top nibble of |s| below the sign bit; the most negative sample reads as full scale.
  function automatic logic [3:0] meter_nibble(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] mag;
    if (s[SAMPLE_W-1]) mag = ~s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    else               mag = s;
    if (mag[SAMPLE_W-1]) mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else                 mag = mag;
    return mag[SAMPLE_W-2 -: 4];
  endfunction

  // Decay first, then take the max with the new level.
  always_comb begin
    decay_s  = (decay_cnt_r == DEC_W'(METER_DECAY - 1));
    nib_l_s  = meter_nibble(sat_l_s);
    nib_r_s  = meter_nibble(sat_r_s);
    if (decay_s) begin
      base_l_s = peak_l >> 1;
      base_r_s = peak_r >> 1;
    end else begin
      base_l_s = peak_l;
      base_r_s = peak_r;
    end
  end

  // Meter registers, updated once per MIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      decay_cnt_r <= {DEC_W{1'b0}};
      peak_l      <= 4'd0;
      peak_r      <= 4'd0;
    end else if (state_r == MIX) begin
      decay_cnt_r <= decay_s ? {DEC_W{1'b0}} : decay_cnt_r + {{(DEC_W-1){1'b0}}, 1'b1};
      peak_l      <= (nib_l_s > base_l_s) ? nib_l_s : base_l_s;
      peak_r      <= (nib_r_s > base_r_s) ? nib_r_s : base_r_s;
    end
  end
`endif

endmodule

// File: tb/tb_multi_channel_sample_bridge.sv
// Bench for multi_channel_sample_bridge: two instances (hold / zero on underrun)
// share one producer bus; a queue-based frame model is compared every cycle.
module tb_multi_channel_sample_bridge;
  localparam int NCH = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stereo_mode = 1'b0;
  logic new_frame = 1'b0;
  logic clear_status = 1'b0;

  multi_channel_sample_bridge_if #(.NUM_CH(NCH), .SAMPLE_W(16)) bus ();

  logic [23:0] hl1, hr1, hl0, hr0;
  logic [15:0] tap1, tap0;
  logic        tv1, tv0, fm1, fm0;
  logic [5:0]  fill1, fill0;
  logic [1:0]  ovf1, ovf0, und1, und0;
`ifdef SAMPLE_BRIDGE_PEAK_METER_EN
  logic [3:0]  pl1, pr1, pl0, pr0;
`endif

  multi_channel_sample_bridge #(.NUM_CH(NCH), .DEPTH(DEP), .HOLD_ON_UNDERRUN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .prod(bus), .stereo_mode(stereo_mode),
    .new_frame(new_frame), .clear_status(clear_status),
    .hphone_l(hl1), .hphone_r(hr1), .tap_sample(tap1), .tap_valid(tv1),
    .fill_level(fill1), .overflow(ovf1), .underrun(und1), .frame_miss(fm1)
`ifdef SAMPLE_BRIDGE_PEAK_METER_EN
    , .peak_l(pl1), .peak_r(pr1)
`endif
  );

  multi_channel_sample_bridge #(.NUM_CH(NCH), .DEPTH(DEP), .HOLD_ON_UNDERRUN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .prod(bus), .stereo_mode(stereo_mode),
    .new_frame(new_frame), .clear_status(clear_status),
    .hphone_l(hl0), .hphone_r(hr0), .tap_sample(tap0), .tap_valid(tv0),
    .fill_level(fill0), .overflow(ovf0), .underrun(und0), .frame_miss(fm0)
`ifdef SAMPLE_BRIDGE_PEAK_METER_EN
    , .peak_l(pl0), .peak_r(pr0)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tap_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic signed [15:0] mq [NCH][$];
  int held [NCH];
  int pend_l1, pend_r1, pend_l0, pend_r0;
  bit pop_pend, out_pend, was_pop, was_out;
  logic [23:0] m_hl1, m_hr1, m_hl0, m_hr0;
  logic [15:0] m_tap1, m_tap0;
  bit m_tv, m_fm;
  bit [1:0] m_ovf, m_und, set_o, set_u;
  int v, v1, v0, sl1, sr1, sl0, sr0;
  logic [15:0] pushed;

  function automatic int clamp16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic logic [23:0] word24(input int s);
    logic [15:0] t;
    t = s[15:0];
    return {t, 8'h00};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        held[c] = 0;
      end
      pop_pend = 0; out_pend = 0;
      pend_l1 = 0; pend_r1 = 0; pend_l0 = 0; pend_r0 = 0;
      m_hl1 = 0; m_hr1 = 0; m_hl0 = 0; m_hr0 = 0; m_tap1 = 0; m_tap0 = 0;
      m_tv = 0; m_fm = 0; m_ovf = 0; m_und = 0;
    end else begin
      was_pop = pop_pend;
      was_out = out_pend;
      m_tv = was_out;
      if (was_out) begin
        m_hl1 = word24(pend_l1); m_hr1 = word24(pend_r1);
        m_hl0 = word24(pend_l0); m_hr0 = word24(pend_r0);
        m_tap1 = pend_l1[15:0];  m_tap0 = pend_l0[15:0];
      end
      set_u = 2'b00;
      if (was_pop) begin
        sl1 = 0; sr1 = 0; sl0 = 0; sr0 = 0;
        for (int c = 0; c < NCH; c++) begin
          if (mq[c].size() > 0) begin
            v = mq[c].pop_front();
            held[c] = v; v1 = v; v0 = v;
          end else begin
            set_u[c] = 1'b1; v1 = held[c]; v0 = 0;
          end
          if (!stereo_mode || (c % 2) == 0) begin sl1 += v1; sl0 += v0; end
          if (!stereo_mode || (c % 2) == 1) begin sr1 += v1; sr0 += v0; end
        end
        pend_l1 = clamp16(sl1); pend_r1 = clamp16(sr1);
        pend_l0 = clamp16(sl0); pend_r0 = clamp16(sr0);
      end
      set_o = 2'b00;
      for (int c = 0; c < NCH; c++) begin
        if (bus.sample_valid[c]) begin
          pushed = bus.sample_in[c*16 +: 16];
          if (mq[c].size() < DEP) mq[c].push_back(pushed);
          else set_o[c] = 1'b1;
        end
      end
      m_fm  = (new_frame && (was_pop || was_out)) || (m_fm && !clear_status);
      m_ovf = set_o | (m_ovf & ~{2{clear_status}});
      m_und = set_u | (m_und & ~{2{clear_status}});
      out_pend = was_pop;
      pop_pend = new_frame && !was_pop && !was_out;
    end
  end

  // Per-cycle compare of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    logic [5:0] ef;
    ef = {3'(mq[1].size()), 3'(mq[0].size())};
    chk("hphone_l", hl1, m_hl1);  chk("hphone_r", hr1, m_hr1);
    chk("tap_sample", tap1, m_tap1); chk("tap_valid", tv1, m_tv);
    chk("fill_level", fill1, ef); chk("overflow", ovf1, m_ovf);
    chk("underrun", und1, m_und); chk("frame_miss", fm1, m_fm);
    chk("z_hphone_l", hl0, m_hl0); chk("z_hphone_r", hr0, m_hr0);
    chk("z_tap_sample", tap0, m_tap0); chk("z_tap_valid", tv0, m_tv);
    chk("z_fill_level", fill0, ef); chk("z_underrun", und0, m_und);
    if (tv1) tap_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [15:0] a, input logic [15:0] b);
    bus.sample_in = {b, a};
    bus.sample_valid = 2'b11;
    tick();
    bus.sample_valid = 2'b00;
  endtask

  task automatic push0(input logic [15:0] a);
    bus.sample_in = {16'h0000, a};
    bus.sample_valid = 2'b01;
    tick();
    bus.sample_valid = 2'b00;
  endtask

  // Ends just after outputs update (tap_valid high now).
  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  initial begin
    bus.sample_in = '0;
    bus.sample_valid = 2'b00;
    tick();
    chk("reset_hphone_l", hl1, 24'h0);
    chk("reset_fill", fill1, 6'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: mono mix and tap strobe
    push2(16'h1000, 16'h0200);
    frame();
    chk("t1_l", hl1, 24'h120000);
    chk("t1_r", hr1, 24'h120000);
    chk("t1_tap_valid", tv1, 1'b1);
    tick();
    chk("t1_tap_valid_off", tv1, 1'b0);

    // 2: positive and negative saturation
    push2(16'h7000, 16'h7000);
    frame();
    chk("t2_pos_sat", hl1, 24'h7FFF00);
    push2(16'h8000, 16'h8000);
    frame();
    chk("t2_neg_sat", hl1, 24'h800000);

    // 3: stereo split
    stereo_mode = 1'b1;
    push2(16'h0100, 16'hFF00);
    frame();
    chk("t3_l", hl1, 24'h010000);
    chk("t3_r", hr1, 24'hFF0000);
    stereo_mode = 1'b0;

    // 4: overflow on the fifth push, then clear
    push0(16'h0010); push0(16'h0020); push0(16'h0030); push0(16'h0040); push0(16'h0050);
    chk("t4_overflow", ovf1[0], 1'b1);
    chk("t4_fill", fill1[2:0], 3'd4);
    pulse_clear();
    chk("t4_cleared", ovf1[0], 1'b0);
    for (int i = 0; i < 4; i++) frame();
    chk("t4_drained", fill1, 6'h0);

    // 5: underrun hold vs zero
    pulse_clear();
    push2(16'h0400, 16'h0000);
    frame();
    chk("t5_pre", hl1, 24'h040000);
    pulse_clear();
    chk("t5_und_clear", und1, 2'b00);
    frame();
    chk("t5_underrun", und1, 2'b11);
    chk("t5_hold", hl1, 24'h040000);
    chk("t5_zero", hl0, 24'h000000);

    // 6: back-to-back new_frame, then reset in MIX
    push2(16'h0001, 16'h0002);
    tap_cnt = 0;
    new_frame = 1'b1;
    tick(); tick();
    new_frame = 1'b0;
    tick(); tick(); tick();
    chk("t6_one_mix", tap_cnt, 1);
    chk("t6_frame_miss", fm1, 1'b1);
    chk("t6_mix", hl1, 24'h000300);
    push2(16'h0005, 16'h0006);
    push2(16'h0007, 16'h0008);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_l", hl1, 24'h0);
    chk("t6_rst_fill", fill1, 6'h0);
    chk("t6_rst_miss", fm1, 1'b0);
    chk("t6_rst_tv", tv1, 1'b0);
    #1;
    reset_n = 1'b1;
    tick(); tick();
    chk("t6_after", hl1, 24'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
